// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the registered 1-to-N stream demultiplexer.
package demux_pkg;

    // Default beat width and lane count for the standard 16-lane build.
    localparam int DATA_W = 128;
    localparam int N_OUT  = 16;
    localparam int SEL_W  = $clog2(N_OUT);

    // Width of the bad-select drop counter.
    localparam int CNT_W  = 16;

    typedef logic [DATA_W-1:0]               data_t;
    typedef logic [SEL_W-1:0]                sel_t;
    typedef logic [0:N_OUT-1][DATA_W-1:0]    lanes_t;
    typedef logic [CNT_W-1:0]                count_t;

    // Lane slice occupancy states.
    localparam logic [0:0] LANE_EMPTY = 1'b0;
    localparam logic [0:0] LANE_FULL  = 1'b1;

    // Ceiling of the drop counter; it sticks here rather than wrapping.
    localparam count_t COUNT_MAX = '1;

    // Saturating increment used by the drop counter.
    function automatic count_t sat_inc(input count_t value);
        return (value == COUNT_MAX) ? value : value + count_t'(1);
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready register slice holding a single beat for one output lane.
// A full slice that is being drained can accept a new beat in the same cycle.
module demux_lane_reg #(
    parameter int DATA_W = demux_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              drain,
    output logic              ready_out,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    import demux_pkg::*;

    logic [0:0] state;
    logic [0:0] next_state;

    // Next occupancy: fill on load, empty on drain without a replacement beat.
    always_comb begin
        next_state = state;
        if (state == LANE_EMPTY) begin
            if (load) begin
                next_state = LANE_FULL;
            end
        end else begin
            if (drain && !load) begin
                next_state = LANE_EMPTY;
            end
        end
    end

    // Occupancy register, cleared so no beat survives reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LANE_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Payload register: captures only on load, otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= data_in;
        end
    end

    assign valid     = (state == LANE_FULL);
    assign ready_out = (state == LANE_EMPTY) || drain;

endmodule

// File: rtl/demux_16.sv
// Registered 1-to-N stream demultiplexer. Each input beat is routed to the lane
// named by in_sel; each lane buffers one beat so a stalled consumer only blocks
// beats addressed to its own lane. Beats with an out-of-range select are
// consumed, dropped, flagged on sel_err and counted in drop_count.
module demux_16 #(
    parameter int DATA_W = demux_pkg::DATA_W,
    parameter int N_OUT  = demux_pkg::N_OUT,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SEL_W-1:0]               in_sel,
    input  logic [DATA_W-1:0]              in_data,
    output logic [N_OUT-1:0]               out_valid,
    input  logic [N_OUT-1:0]               out_ready,
    output logic [0:N_OUT-1][DATA_W-1:0]   out_data,
    output logic                           sel_err,
    output logic [15:0]                    drop_count
);
    import demux_pkg::*;

    logic              sel_ok;
    logic              lane_ready_sel;
    logic              accept;
    logic              drop;
    logic [N_OUT-1:0]  sel_hot;
    logic [N_OUT-1:0]  lane_ready;
    logic [N_OUT-1:0]  lane_load;

    // Decode the select into a one-hot lane vector and pick that lane's ready.
    // Selects at or beyond N_OUT match no lane, which is what marks them bad.
    always_comb begin
        sel_hot        = '0;
        lane_ready_sel = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hot[i]     = 1'b1;
                lane_ready_sel = lane_ready[i];
            end
        end
    end

    // A bad-select beat is always accepted so it cannot wedge the ingress bus.
    assign sel_ok    = |sel_hot;
    assign in_ready  = sel_ok ? lane_ready_sel : 1'b1;
    assign accept    = in_valid && in_ready;
    assign drop      = accept && !sel_ok;
    assign lane_load = accept ? sel_hot : '0;

    // One register slice per output lane.
    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        demux_lane_reg #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (lane_load[g]),
            .data_in   (in_data),
            .drain     (out_ready[g]),
            .ready_out (lane_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g])
        );
    end

    // Error pulse and saturating drop counter for beats with a bad select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err    <= 1'b0;
            drop_count <= '0;
        end else begin
            sel_err <= drop;
            if (drop) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

endmodule

// File: tb/tb_demux_16.sv
// Self-checking bench for demux_16: a 16-lane instance driven from a vector
// table and hand sequences, plus a 12-lane instance for bad-select handling.
module tb_demux_16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // 16-lane instance
    logic                  in_valid_a = 1'b0;
    logic                  in_ready_a;
    logic [3:0]            in_sel_a   = '0;
    logic [127:0]          in_data_a  = '0;
    logic [15:0]           out_valid_a;
    logic [15:0]           out_ready_a = '0;
    logic [0:15][127:0]    out_data_a;
    logic                  sel_err_a;
    logic [15:0]           drop_count_a;

    // 12-lane instance
    logic                  in_valid_b = 1'b0;
    logic                  in_ready_b;
    logic [3:0]            in_sel_b   = '0;
    logic [127:0]          in_data_b  = '0;
    logic [11:0]           out_valid_b;
    logic [11:0]           out_ready_b = '1;
    logic [0:11][127:0]    out_data_b;
    logic                  sel_err_b;
    logic [15:0]           drop_count_b;

    int total = 0;
    int bad   = 0;
    int err_a_hits = 0;
    int err_b_hits = 0;

    typedef struct {
        logic         vld;
        logic [3:0]   sel;
        logic [127:0] data;
        logic [15:0]  rdy;
        logic         exp_ready;
        logic [15:0]  exp_valid;
        int           exp_lane;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    demux_16 #(.N_OUT(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .in_sel     (in_sel_a),
        .in_data    (in_data_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a),
        .out_data   (out_data_a),
        .sel_err    (sel_err_a),
        .drop_count (drop_count_a)
    );

    demux_16 #(.N_OUT(12)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_sel     (in_sel_b),
        .in_data    (in_data_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_data   (out_data_b),
        .sel_err    (sel_err_b),
        .drop_count (drop_count_b)
    );

    // Input stream on the 16-lane instance must stay stable while stalled.
    logic         pend_q = 1'b0;
    logic [3:0]   pend_sel = '0;
    logic [127:0] pend_data = '0;
    always @(posedge clk) begin
        if (rst_n && pend_q) begin
            assert (in_valid_a && in_sel_a == pend_sel && in_data_a == pend_data)
                else $error("[TB] input stream changed while stalled");
        end
        pend_q    <= rst_n && in_valid_a && !in_ready_a;
        pend_sel  <= in_sel_a;
        pend_data <= in_data_a;
    end

    // Count error pulses on both instances, sampled away from the clock edge.
    always @(negedge clk) begin
        if (sel_err_a === 1'b1) err_a_hits++;
        if (sel_err_b === 1'b1) err_b_hits++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input logic vld, input logic [3:0] sel, input logic [127:0] data,
                                      input logic [15:0] rdy, input logic exp_ready,
                                      input logic [15:0] exp_valid, input int exp_lane,
                                      input logic [127:0] exp_data);
        vec_t v;
        v.vld = vld; v.sel = sel; v.data = data; v.rdy = rdy;
        v.exp_ready = exp_ready; v.exp_valid = exp_valid;
        v.exp_lane = exp_lane; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v, input int idx);
        in_valid_a  = v.vld;
        in_sel_a    = v.sel;
        in_data_a   = v.data;
        out_ready_a = v.rdy;
        #1;
        if (v.vld) check_output($sformatf("v%0d in_ready", idx), 128'(in_ready_a), 128'(v.exp_ready));
        tick();
        check_output($sformatf("v%0d out_valid", idx), 128'(out_valid_a), 128'(v.exp_valid));
        if (v.exp_lane >= 0)
            check_output($sformatf("v%0d out_data", idx), out_data_a[v.exp_lane], v.exp_data);
    endtask

    task automatic bad_beat_b(input logic [3:0] sel, input logic [15:0] exp_drop, input string name);
        in_valid_b = 1'b1;
        in_sel_b   = sel;
        in_data_b  = 128'hDEAD;
        #1;
        check_output({name, " in_ready"}, 128'(in_ready_b), 128'(1));
        tick();
        check_output({name, " sel_err"}, 128'(sel_err_b), 128'(1));
        check_output({name, " drop_count"}, 128'(drop_count_b), 128'(exp_drop));
        check_output({name, " out_valid"}, 128'(out_valid_b), 128'(0));
    endtask

    initial begin
        // Routing sweep: lane i fills then drains the next cycle.
        for (int i = 0; i < 16; i++)
            vecs.push_back(make_vec(1'b1, 4'(i), 128'('hA0 + i), 16'hFFFF, 1'b1,
                                    16'(1 << i), i, 128'('hA0 + i)));
        vecs.push_back(make_vec(1'b0, 4'd0, '0, 16'hFFFF, 1'b1, 16'h0000, -1, '0));
        // Backpressure on lane 5, lane 6 unaffected, in-order delivery.
        vecs.push_back(make_vec(1'b1, 4'd5, 128'hB0, 16'hFFDF, 1'b1, 16'h0020, 5, 128'hB0));
        vecs.push_back(make_vec(1'b1, 4'd6, 128'hC0, 16'hFFDF, 1'b1, 16'h0060, 6, 128'hC0));
        vecs.push_back(make_vec(1'b1, 4'd5, 128'hB1, 16'hFFDF, 1'b0, 16'h0020, 5, 128'hB0));
        vecs.push_back(make_vec(1'b1, 4'd5, 128'hB1, 16'hFFDF, 1'b0, 16'h0020, 5, 128'hB0));
        vecs.push_back(make_vec(1'b1, 4'd5, 128'hB1, 16'hFFFF, 1'b1, 16'h0020, 5, 128'hB1));
        vecs.push_back(make_vec(1'b0, 4'd5, 128'hB1, 16'hFFFF, 1'b1, 16'h0000, -1, '0));
        // Simultaneous drain and load on lane 2.
        vecs.push_back(make_vec(1'b1, 4'd2, 128'hD0, 16'hFFFF, 1'b1, 16'h0004, 2, 128'hD0));
        vecs.push_back(make_vec(1'b1, 4'd2, 128'hD1, 16'hFFFF, 1'b1, 16'h0004, 2, 128'hD1));
        vecs.push_back(make_vec(1'b0, 4'd2, 128'hD1, 16'hFFFF, 1'b1, 16'h0000, -1, '0));

        // Reset with a live input beat pending.
        rst_n = 1'b0;
        in_valid_a = 1'b1; in_sel_a = 4'd3; in_data_a = 128'h33; out_ready_a = '0;
        tick();
        tick();
        check_output("rst out_valid_a", 128'(out_valid_a), 128'(0));
        check_output("rst drop_count_a", 128'(drop_count_a), 128'(0));
        check_output("rst in_ready_a", 128'(in_ready_a), 128'(1));
        check_output("rst out_valid_b", 128'(out_valid_b), 128'(0));
        check_output("rst drop_count_b", 128'(drop_count_b), 128'(0));
        check_output("rst sel_err_b", 128'(sel_err_b), 128'(0));
        rst_n = 1'b1;
        in_valid_a = 1'b0;
        tick();

        for (int k = 0; k < vecs.size(); k++)
            apply_stimulus(vecs[k], k);

        // Reset while lanes 0 and 7 hold stalled beats.
        in_valid_a = 1'b1; in_sel_a = 4'd0; in_data_a = 128'hE0; out_ready_a = 16'hFF7E;
        tick();
        in_sel_a = 4'd7; in_data_a = 128'hE7;
        tick();
        check_output("pre-rst out_valid", 128'(out_valid_a), 128'(16'h0081));
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        tick();
        check_output("mid-rst out_valid", 128'(out_valid_a), 128'(0));
        check_output("mid-rst data0", out_data_a[0], 128'(0));
        check_output("mid-rst data7", out_data_a[7], 128'(0));
        rst_n = 1'b1;
        in_valid_a = 1'b1; in_sel_a = 4'd7; in_data_a = 128'hF7; out_ready_a = 16'hFFFF;
        #1;
        check_output("post-rst in_ready", 128'(in_ready_a), 128'(1));
        tick();
        check_output("post-rst out_valid", 128'(out_valid_a), 128'(16'h0080));
        check_output("post-rst data7", out_data_a[7], 128'hF7);
        in_valid_a = 1'b0;
        tick();
        check_output("post-rst drained", 128'(out_valid_a), 128'(0));

        // Bad select on the 12-lane instance.
        err_b_hits = 0;
        bad_beat_b(4'd13, 16'd1, "bad1");
        bad_beat_b(4'd13, 16'd2, "bad2");
        bad_beat_b(4'd13, 16'd3, "bad3");
        in_valid_b = 1'b1; in_sel_b = 4'd11; in_data_b = 128'h5B;
        #1;
        check_output("good11 in_ready", 128'(in_ready_b), 128'(1));
        tick();
        check_output("good11 out_valid", 128'(out_valid_b), 128'(12'h800));
        check_output("good11 data", out_data_b[11], 128'h5B);
        check_output("good11 sel_err", 128'(sel_err_b), 128'(0));
        check_output("good11 drop_count", 128'(drop_count_b), 128'(3));
        in_valid_b = 1'b0;
        tick();
        check_output("idle out_valid_b", 128'(out_valid_b), 128'(0));
        check_output("sel_err pulses", 128'(err_b_hits), 128'(3));

        // Push the counter up to one below saturation using the boundary select.
        in_valid_b = 1'b1; in_sel_b = 4'd12;
        for (int k = 0; k < 65531; k++) tick();
        in_valid_b = 1'b0;
        tick();
        check_output("drop_count fffe", 128'(drop_count_b), 128'(16'hFFFE));
        check_output("sel_err idle", 128'(sel_err_b), 128'(0));
        check_output("no lane on sel 12", 128'(out_valid_b), 128'(0));
        bad_beat_b(4'd13, 16'hFFFF, "sat1");
        bad_beat_b(4'd13, 16'hFFFF, "sat2");
        bad_beat_b(4'd13, 16'hFFFF, "sat3");
        in_valid_b = 1'b0;
        tick();

        // The full 16-lane build can never see a bad select.
        check_output("a sel_err never", 128'(err_a_hits), 128'(0));
        check_output("a drop_count", 128'(drop_count_a), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
